ps2_key_decoder: RTL and testbench

- Parametrised successor to the ad-hoc PS/2 capture used by the VGA demos.
- Receives PS/2 keyboard frames with glitch filtering, start/parity/stop checking and an idle timeout.
- Folds E0 (extended) and F0 (break) prefixes into single key events, queued in a first-word-fall-through FIFO with a valid/ready handshake.
- Maintains a held-state bitmap of the four arrow keys with both press and release tracking, driving square/cursor movers in the video designs.

---
 rtl/ps2_key_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver and key-event decoder with a FWFT event FIFO and arrow-key held state.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated make codes while a key is held.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 2500,
  parameter int FIFO_AW    = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [3:0] arrows,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      FLT_MAX = 4'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             flt_clk_q, flt_clk_d, flt_prev_q;
  logic [3:0]       flt_cnt_q, flt_cnt_d;
  logic             fall, timeout;
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       shift_q, shift_d, byte_q, byte_d;
  logic             par_q, par_d, good_q, good_d;
  logic             err_frame_q, err_frame_d, err_parity_q, err_parity_d;
  logic             ext_q, ext_d, brk_q, brk_d, emit, push;
  logic [3:0]       arrows_q, arrows_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full, pop, wr_en, overflow_q, overflow_d;
  logic [9:0]       mem [DEPTH];
  logic [9:0]       head;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0]       last_q, last_d;
  logic             last_vld_q, last_vld_d;
`endif

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples
  always_comb begin
    flt_clk_d = flt_clk_q;
    flt_cnt_d = 4'd0;
    if (clk_s2_q != flt_clk_q) begin
      if (flt_cnt_q == FLT_MAX) flt_clk_d = clk_s2_q;
      else                      flt_cnt_d = flt_cnt_q + 4'd1;
    end
  end

  assign fall    = flt_prev_q & ~flt_clk_q;
  assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_MAX);
  assign to_cnt_d = (state_q == IDLE || fall || timeout) ? '0 : to_cnt_q + TO_W'(1);

  always_ff @(posedge vga_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) state_d = IDLE;
    else if (fall) begin
      case (state_q)
        IDLE:    if (!dat_s2_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  // Stop-bit errors take priority over parity errors
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_d       = byte_q;
    good_d       = 1'b0;
    err_frame_d  = 1'b0;
    err_parity_d = 1'b0;
    if (timeout) err_frame_d = 1'b1;
    else if (fall) begin
      case (state_q)
        IDLE: begin
          if (dat_s2_q) err_frame_d = 1'b1;
          else          bit_cnt_d   = 3'd0;
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: par_d = dat_s2_q;
        default: begin
          if (!dat_s2_q)                  err_frame_d  = 1'b1;
          else if (!(^{shift_q, par_q}))  err_parity_d = 1'b1;
          else begin
            good_d = 1'b1;
            byte_d = shift_q;
          end
        end
      endcase
    end
  end

  // Prefix folding and arrow held-state tracking
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    arrows_d = arrows_q;
    emit     = 1'b0;
    if (err_frame_q || err_parity_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (good_q) begin
      if (byte_q == 8'hE0)      ext_d = 1'b1;
      else if (byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        emit  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (emit && ext_q) begin
      case (byte_q)
        8'h75:   arrows_d[3] = ~brk_q;
        8'h6B:   arrows_d[2] = ~brk_q;
        8'h72:   arrows_d[1] = ~brk_q;
        8'h74:   arrows_d[0] = ~brk_q;
        default: ;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    push       = emit;
    if (emit) begin
      if (brk_q) last_vld_d = 1'b0;
      else if (last_vld_q && last_q == {byte_q, ext_q}) push = 1'b0;
      else begin
        last_d     = {byte_q, ext_q};
        last_vld_d = 1'b1;
      end
    end
  end
`else
  assign push = emit;
`endif

  assign ev_valid = (wr_ptr_q != rd_ptr_q);
  assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop        = ev_valid & ev_ready;
  assign wr_en      = push & (~full | pop);
  assign overflow_d = push & full & ~pop;
  assign wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, wr_en};
  assign rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
  assign head       = mem[rd_ptr_q[FIFO_AW-1:0]];
  assign ev_code    = ev_valid ? head[9:2] : 8'h00;
  assign ev_ext     = ev_valid & head[1];
  assign ev_break   = ev_valid & head[0];
  assign arrows     = arrows_q;
  assign err_frame  = err_frame_q;
  assign err_parity = err_parity_q;
  assign overflow   = overflow_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      flt_clk_q    <= 1'b1;
      flt_prev_q   <= 1'b1;
      flt_cnt_q    <= 4'd0;
      bit_cnt_q    <= 3'd0;
      to_cnt_q     <= '0;
      good_q       <= 1'b0;
      err_frame_q  <= 1'b0;
      err_parity_q <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      arrows_q     <= 4'b0000;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      flt_clk_q    <= flt_clk_d;
      flt_prev_q   <= flt_clk_q;
      flt_cnt_q    <= flt_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      good_q       <= good_d;
      err_frame_q  <= err_frame_d;
      err_parity_q <= err_parity_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      arrows_q     <= arrows_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  always_ff @(posedge vga_clk) begin
    if (reset) last_vld_q <= 1'b0;
    else       last_vld_q <= last_vld_d;
    last_q <= last_d;
  end
`endif

  always_ff @(posedge vga_clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    byte_q  <= byte_d;
    if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= {byte_q, ext_q, brk_q};
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames, events checked by a monitor.
module tb_ps2_key_decoder;
  localparam int HALF = 20;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b1;
  logic       ev_valid, ev_ext, ev_break, err_parity, err_frame, overflow;
  logic [7:0] ev_code;
  logic [3:0] arrows;

  int n_chk = 0, n_pass = 0;
  int n_ef = 0, n_ep = 0, n_ov = 0, n_pop = 0;
  int ef0, ep0, ov0, p0;
  logic [9:0] exp_q [$];
  logic [9:0] e;

  always #20 vga_clk = ~vga_clk;

  ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT(2500), .FIFO_AW(2)) dut (
    .vga_clk(vga_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .arrows(arrows), .err_parity(err_parity),
    .err_frame(err_frame), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  // hook 1: check event latency after the stop-bit edge; hook 2: pulse ev_ready on the push cycle
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_bit, input int hook);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && hook == 1) begin
        wait_cyc(7);
        check("latency_pre", ev_valid, 1'b0);
        wait_cyc(1);
        check("latency_valid", ev_valid, 1'b1);
        wait_cyc(HALF - 8);
      end else if (i == 10 && hook == 2) begin
        wait_cyc(7);
        ev_ready = 1'b1;
        wait_cyc(1);
        ev_ready = 1'b0;
        wait_cyc(HALF - 8);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i <= nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  always @(negedge vga_clk) begin
    if (!reset) begin
      if (err_frame)  n_ef++;
      if (err_parity) n_ep++;
      if (overflow)   n_ov++;
      if (ev_valid && ev_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got code=%0h ext=%0b brk=%0b expected none", ev_code, ev_ext, ev_break);
        end else begin
          e = exp_q.pop_front();
          check("event", {ev_code, ev_ext, ev_break}, e);
        end
      end
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    wait_cyc(5);
    check("reset_outputs", {ev_valid, ev_code, ev_ext, ev_break, arrows, err_parity, err_frame, overflow}, 0);
    reset = 1'b0;
    wait_cyc(5);

    // Basic make code and latency
    exp_q.push_back({8'h1C, 2'b00});
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    check("no_err_frame", n_ef, 0);
    check("no_err_parity", n_ep, 0);

    // Extended arrow make then break
    exp_q.push_back({8'h75, 2'b10});
    send_byte(8'hE0); send_byte(8'h75);
    check("arrows_up_held", arrows, 4'b1000);
    exp_q.push_back({8'h75, 2'b11});
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("arrows_up_released", arrows, 4'b0000);

    // Parity error, then framing error discarding the E0 prefix
    ef0 = n_ef; ep0 = n_ep;
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    check("parity_err_count", n_ep, ep0 + 1);
    check("parity_no_frame_err", n_ef, ef0);
    send_byte(8'hE0);
    send_frame(8'h33, 1'b0, 1'b0, 0);
    check("stop_err_count", n_ef, ef0 + 1);
    check("stop_no_parity_err", n_ep, ep0 + 1);
    exp_q.push_back({8'h6B, 2'b00});
    send_byte(8'h6B);
    check("arrows_after_plain_6b", arrows, 4'b0000);

    // Overflow with a stalled consumer, then simultaneous push and pop while full
    ev_ready = 1'b0;
    ov0 = n_ov;
    exp_q.push_back({8'h1C, 2'b00});
    exp_q.push_back({8'h32, 2'b00});
    exp_q.push_back({8'h21, 2'b00});
    exp_q.push_back({8'h23, 2'b00});
    send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21); send_byte(8'h23); send_byte(8'h24);
    check("overflow_count", n_ov, ov0 + 1);
    check("full_valid", ev_valid, 1'b1);
    exp_q.push_back({8'h2B, 2'b00});
    send_frame(8'h2B, 1'b0, 1'b1, 2);
    check("no_overflow_on_push_pop", n_ov, ov0 + 1);
    p0 = n_pop;
    ev_ready = 1'b1;
    wait_cyc(10);
    check("drained_occupancy", n_pop - p0, 4);
    check("drained_empty", ev_valid, 1'b0);

    // Timeout after 4 data bits, then a good frame
    ef0 = n_ef;
    send_partial(8'h29, 4);
    wait_cyc(2400);
    check("timeout_not_early", n_ef, ef0);
    wait_cyc(200);
    check("timeout_err", n_ef, ef0 + 1);
    ps2_data = 1'b1;
    wait_cyc(10);
    exp_q.push_back({8'h29, 2'b00});
    send_byte(8'h29);

    // Short glitches on ps2_clk while idle sample nothing
    ef0 = n_ef;
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0; wait_cyc(2);
      ps2_clk = 1'b1; wait_cyc(10);
    end
    check("glitch_no_sample", n_ef, ef0);

    // Reset mid-prefix and mid-frame
    exp_q.push_back({8'h74, 2'b10});
    send_byte(8'hE0); send_byte(8'h74);
    check("arrows_right_held", arrows, 4'b0001);
    send_byte(8'hE0);
    send_partial(8'h12, 3);
    reset = 1'b1;
    wait_cyc(3);
    check("midframe_reset_outputs", {ev_valid, ev_code, ev_ext, ev_break, arrows, err_parity, err_frame, overflow}, 0);
    reset = 1'b0;
    ps2_data = 1'b1;
    wait_cyc(5);
    exp_q.push_back({8'h1C, 2'b00});
    send_byte(8'h1C);

    // Typematic repeats of an extended arrow
    exp_q.push_back({8'h74, 2'b10});
`ifndef PS2_TYPEMATIC_FILTER_EN
    exp_q.push_back({8'h74, 2'b10});
    exp_q.push_back({8'h74, 2'b10});
`endif
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hE0); send_byte(8'h74);
    end
    check("typematic_arrows_held", arrows, 4'b0001);
    exp_q.push_back({8'h74, 2'b11});
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    check("typematic_arrows_released", arrows, 4'b0000);

    wait_cyc(20);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
